divider_1: RTL
==============

DIVIDER_1 -- requirements
Module: divider_1

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits.
REQ-002 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-003 Port res_n  input  1  is the reset, asynchronous and active-low.
REQ-004 Port start  input  1  is the request to begin a division, sampled at the rising edge of clk.
REQ-005 Port arg1  input  WIDTH  is the dividend, unsigned.
REQ-006 Port arg2  input  WIDTH  is the divisor, unsigned.
REQ-007 Port busy  output  1  is high while a division is in progress.
REQ-008 Port done  output  1  is high while quotient and remainder hold a valid result.
REQ-009 Port quotient  output  WIDTH  is the registered quotient.
REQ-010 Port remainder  output  WIDTH  is the registered remainder.
REQ-011 Port div0  output  1  flags a zero-divisor result; this port exists only when DIVIDER_DIV0_ERR_EN is defined.

Function
REQ-012 The block SHALL divide by repeated subtraction, at most one subtraction per clock cycle.
REQ-013 The FSM SHALL have exactly three states: IDLE, SUB and DONE.
REQ-014 In IDLE or DONE, start=1 at an edge SHALL capture arg1 and arg2, clear done, and load quotient=0 and remainder=arg1.
- If arg2!=0, the FSM SHALL enter SUB with busy=1.
REQ-015 In SUB, at each edge where remainder>=divisor, the block SHALL set remainder=remainder-divisor and quotient=quotient+1, and stay in SUB.
REQ-016 In SUB, at the first edge where remainder<divisor, the FSM SHALL enter DONE: busy=0, done=1, and the outputs are frozen.
REQ-017 Latency SHALL be exactly Q+1 edges from the start-accepting edge to done=1, where Q is the final quotient.
- Worst case is 2^WIDTH edges, for (2^WIDTH-1)/1.
REQ-018 If arg2==0 when start is accepted, the FSM SHALL go directly to DONE on that edge.
- Result: quotient = all ones, remainder = arg1, busy = 0.
REQ-019 start SHALL be ignored while in SUB.
REQ-020 arg1 and arg2 SHALL be ignored except at the start-accepting edge; later changes SHALL NOT affect the result.
REQ-021 done, quotient and remainder SHALL hold in DONE until the next accepted start.
- On that start edge: done=0, and the new operands are loaded.
REQ-022 The quotient counter SHALL be WIDTH bits and SHALL NOT wrap, because Q<=arg1.
REQ-023 busy and done SHALL never both be 1.

Reset
REQ-024 res_n=0 SHALL immediately force the following, regardless of clk:
- state = IDLE
- busy = 0, done = 0
- quotient = 0, remainder = 0
- div0 = 0, when present.
REQ-025 Reset asserted mid-division SHALL abort the division with no result retained.
REQ-026 After res_n rises, the block SHALL accept start no earlier than the first following rising edge.

Configuration
REQ-027 The macro DIVIDER_DIV0_ERR_EN SHALL control the zero-divisor flag.
- Defined: div0 is 1 together with done for a zero-divisor division, 0 for every other result, and is cleared when start is accepted.
- Undefined: port div0 is absent, and zero-divisor behaviour follows REQ-018 only.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Start with 7/2 -> quotient=3, remainder=1; done=1 after exactly 4 edges; busy=1 for those 4 cycles.
- Start with 100/7 -> quotient=14, remainder=2 after 15 edges; arg1 changed to 0 mid-run has no effect.
- Start with 5/9 -> quotient=0, remainder=5, done=1 after 1 edge; a second start with 9/3 -> done drops, then quotient=3, remainder=0 after 4 edges.
- Start with 12/0 -> done=1 after 1 edge, quotient=0xFFFF, remainder=12; div0=1 when DIVIDER_DIV0_ERR_EN is defined.
- Start with 1000/1, assert res_n=0 after 10 edges -> all outputs 0 immediately; start pulses during SUB have no effect.
- Start with 65535/1 -> quotient=65535, remainder=0, done=1 after exactly 65536 edges.

Source files
------------

// File: rtl/divider_1.sv
// divider_1 : unsigned WIDTH-bit divider using repeated subtraction,
// at most one subtraction per clock.
// Optional feature: define DIVIDER_DIV0_ERR_EN to add the div0 output,
// which flags results produced by a zero divisor.
// Zero divisor: the block goes straight to DONE with quotient = all ones and
// remainder = dividend.
module divider_1 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             start,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
`ifdef DIVIDER_DIV0_ERR_EN
  ,
  output logic             div0
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] r_divisor;
  logic             w_accept;
  logic             w_div_zero;
  logic             w_can_sub;
`ifdef DIVIDER_DIV0_ERR_EN
  logic             r_div0;
`endif

  // A new request is only taken when no division is running.
  assign w_accept   = start && (r_state != SUB);
  assign w_div_zero = (arg2 == '0);
  // The quotient counter cannot wrap: it counts at most arg1 subtractions.
  assign w_can_sub  = (r_remainder >= r_divisor);

  // State register with asynchronous reset back to IDLE.
  always_ff @(posedge clk or negedge res_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (!res_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default-assign first so no path leaves w_state_nxt unassigned,
    // which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = w_div_zero ? DONE : SUB;
        end
      end
      SUB: begin
        if (!w_can_sub) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load operands on an accepted start, subtract once per cycle in SUB.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_quotient  <= '0;
      r_remainder <= '0;
      r_divisor   <= '0;
`ifdef DIVIDER_DIV0_ERR_EN
      r_div0      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_divisor   <= arg2;
      r_remainder <= arg1;
      r_quotient  <= w_div_zero ? '1 : '0;
`ifdef DIVIDER_DIV0_ERR_EN
      r_div0      <= w_div_zero;
`endif
    end else if ((r_state == SUB) && w_can_sub) begin
      r_remainder <= r_remainder - r_divisor;
      r_quotient  <= r_quotient + 1'b1;
    end
  end

  // Status outputs decode directly from the state, so busy and done are exclusive.
  always_comb begin
    busy = (r_state == SUB);
    done = (r_state == DONE);
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
`ifdef DIVIDER_DIV0_ERR_EN
  assign div0      = r_div0;
`endif

endmodule
